// File: rtl/mips_defs.sv
// mips_defs: MIPS opcode constants shared by the imem loader and the control decoder.
package mips_defs;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
endpackage

// File: rtl/imem_loader_op_legal.sv
// op_legal: flags opcodes the control decoder supports.
module op_legal
  import mips_defs::*;
(
  input  logic [5:0] opcode,
  output logic       legal
);
  assign legal = opcode inside {OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_ORI, OP_LB, OP_LW, OP_SW};
endmodule

// File: rtl/imem_loader.sv
// imem_loader: assembles a big-endian byte stream into 32-bit words and writes them to imem.
module imem_loader
  import mips_defs::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_cnt,
  output logic              illegal_op,
  output logic              overflow
);
  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_e;
  localparam logic [ADDR_W:0] CAP = (ADDR_W+1)'((1 << ADDR_W) - BASE_ADDR);
  state_e            state_q, state_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              ill_q, ill_d, ovf_q, ovf_d, last_q, last_d, legal, full;
  op_legal u_op_legal (.opcode(word_q[31:26]), .legal(legal));
  assign full       = cnt_q == CAP;
  assign in_ready   = state_q == LOAD;
  assign imem_we    = state_q == WRITE && !full;
  assign imem_addr  = addr_q;
  assign imem_wdata = word_q;
  assign busy       = state_q == LOAD || state_q == WRITE;
  assign cpu_hold   = busy;
  assign done       = state_q == DONE;
  assign word_cnt   = cnt_q;
  assign illegal_op = ill_q;
  assign overflow   = ovf_q;
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    ill_d   = ill_q;
    ovf_d   = ovf_q;
    last_d  = last_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = LOAD;
        word_d  = '0;
        idx_d   = '0;
        addr_d  = ADDR_W'(BASE_ADDR);
        cnt_d   = '0;
        ill_d   = 1'b0;
        ovf_d   = 1'b0;
        last_d  = 1'b0;
      end
      LOAD: if (in_valid) begin
        // word is cleared between words, so an early in_last leaves the low bytes zero
        word_d  = word_q | ({in_data, 24'h0} >> {idx_q, 3'b000});
        idx_d   = idx_q + 2'd1;
        last_d  = in_last;
        state_d = (in_last || idx_q == 2'd3) ? WRITE : LOAD;
      end
      WRITE: begin
        idx_d   = '0;
        word_d  = '0;
        ovf_d   = ovf_q | full;
        cnt_d   = full ? cnt_q : cnt_q + 1'b1;
        addr_d  = (full || addr_q == '1) ? addr_q : addr_q + 1'b1;
        ill_d   = ill_q | (!full && !legal);
        state_d = (full || last_q) ? DONE : LOAD;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
      ovf_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
      ovf_q   <= ovf_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed vector bench for imem_loader, plus a small-depth instance for overflow.
module tb_imem_loader;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [7:0] in_data = 8'h0;
  logic in_ready, imem_we, cpu_hold, busy, done, illegal_op, overflow;
  logic [7:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0] word_cnt;
  logic s_start = 1'b0, s_valid = 1'b0, s_last = 1'b0;
  logic [7:0] s_data = 8'h0;
  logic o2_ready, o2_we, o2_hold, o2_busy, o2_done, o2_ill, o2_ovf;
  logic [1:0] o2_addr;
  logic [31:0] o2_wdata;
  logic [2:0] o2_cnt;
  imem_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .busy(busy), .done(done),
    .word_cnt(word_cnt), .illegal_op(illegal_op), .overflow(overflow));
  imem_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
    .clk(clk), .rst(rst), .start(s_start), .in_valid(s_valid), .in_data(s_data),
    .in_last(s_last), .in_ready(o2_ready), .imem_we(o2_we), .imem_addr(o2_addr),
    .imem_wdata(o2_wdata), .cpu_hold(o2_hold), .busy(o2_busy), .done(o2_done),
    .word_cnt(o2_cnt), .illegal_op(o2_ill), .overflow(o2_ovf));
  logic [39:0] wq[$];
  logic [39:0] wq2[$];
  always @(posedge clk) if (imem_we) wq.push_back({imem_addr, imem_wdata});
  always @(posedge clk) if (o2_we) wq2.push_back({6'b0, o2_addr, o2_wdata});
  int total = 0, bad = 0;
  bit hold_chk = 1'b0;
  typedef struct packed {
    logic [3:0]  n;
    logic [63:0] b;
    logic [1:0]  nw;
    logic [63:0] w;
    logic        ill;
  } vec_t;
  vec_t vt[8];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wq.delete();
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_cnt", word_cnt, 0);
    chk("start_ill", illegal_op, 0);
    chk("start_ovf", overflow, 0);
    chk("start_ready", in_ready, 1);
  endtask
  task automatic send(input logic [7:0] b, input bit last, input bit gap, input bit mid);
    int n = 0;
    in_valid = 1'b1;
    in_data = b;
    in_last = last;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", n < 50, 1);
    if (hold_chk) chk("cpu_hold", cpu_hold, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    if (gap) begin
      start = mid;
      @(negedge clk);
      start = 1'b0;
    end
  endtask
  task automatic run_prog(input vec_t v, input bit gap, input bit mid);
    int n = 0;
    logic [39:0] e;
    do_start();
    for (int i = 0; i < 32'(v.n); i++) send(v.b[63-8*i -: 8], i == 32'(v.n) - 1, gap, mid);
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("done", done, 1);
    chk("busy_end", busy, 0);
    chk("hold_end", cpu_hold, 0);
    chk("ready_end", in_ready, 0);
    chk("word_cnt", word_cnt, 64'(v.nw));
    chk("illegal_op", illegal_op, 64'(v.ill));
    chk("overflow", overflow, 0);
    chk("nwrites", wq.size(), 64'(v.nw));
    for (int k = 0; k < 32'(v.nw); k++) begin
      e = (k < wq.size()) ? wq[k] : 40'hx;
      chk("waddr", e[39:32], 64'(k));
      chk("wdata", e[31:0], v.w[63-32*k -: 32]);
    end
  endtask
  initial begin
    int n;
    vt[0] = '{4'd8, 64'h8C010004_00221820, 2'd2, 64'h8C010004_00221820, 1'b0};
    vt[1] = '{4'd3, 64'hAC0100_0000000000, 2'd1, 64'hAC010000_00000000, 1'b0};
    vt[2] = '{4'd4, 64'hFC000000_00000000, 2'd1, 64'hFC000000_00000000, 1'b1};
    vt[3] = '{4'd5, 64'h10220003_08000000, 2'd2, 64'h10220003_08000000, 1'b0};
    vt[4] = '{4'd6, 64'h20410005_34420000, 2'd2, 64'h20410005_34420000, 1'b0};
    vt[5] = '{4'd1, 64'h80000000_00000000, 2'd1, 64'h80000000_00000000, 1'b0};
    vt[6] = '{4'd8, 64'h8C000000_04000000, 2'd2, 64'h8C000000_04000000, 1'b1};
    vt[7] = '{4'd2, 64'hAD210000_00000000, 2'd1, 64'hAD210000_00000000, 1'b0};
    repeat (2) @(negedge clk);
    chk("rst_outs", {in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, word_cnt, illegal_op, overflow}, 0);
    chk("rst_outs2", {o2_ready, o2_we, o2_addr, o2_wdata, o2_hold, o2_busy, o2_done, o2_cnt, o2_ill, o2_ovf}, 0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) run_prog(vt[i], 1'b0, 1'b0);
    // async reset mid-word: everything clears without waiting for a clock
    do_start();
    send(8'h8C, 1'b0, 1'b0, 1'b0);
    send(8'h01, 1'b0, 1'b0, 1'b0);
    chk("busy_pre_rst", busy, 1);
    #2 rst = 1'b1;
    #1 chk("async_rst_outs", {in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, word_cnt, illegal_op, overflow}, 0);
    @(negedge clk);
    rst = 1'b0;
    run_prog(vt[0], 1'b0, 1'b0);
    do_start();
    for (int i = 0; i < 4; i++) send(vt[0].b[63-8*i -: 8], 1'b0, 1'b0, 1'b0);
    chk("we_in_write", imem_we, 1);
    #2 rst = 1'b1;
    #1 chk("we_drop_rst", imem_we, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("no_write_after_rst", wq.size(), 0);
    chk("idle_after_rst", busy, 0);
    // gaps on in_valid with ignored start pulses in between
    hold_chk = 1'b1;
    run_prog(vt[0], 1'b1, 1'b1);
    hold_chk = 1'b0;
    // overflow on a 4-word memory
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1;
      s_data = 8'(i);
      s_last = (i == 19);
      n = 0;
      while (!o2_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("ovf_ready_wait", n < 50, 1);
      @(negedge clk);
      s_valid = 1'b0;
      s_last = 1'b0;
    end
    n = 0;
    while (!o2_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ovf_done", o2_done, 1);
    chk("ovf_flag", o2_ovf, 1);
    chk("ovf_cnt", o2_cnt, 4);
    chk("ovf_ill", o2_ill, 1);
    chk("ovf_nwrites", wq2.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk("ovf_waddr", (k < wq2.size()) ? wq2[k][39:32] : 8'hx, 64'(k));
      chk("ovf_wdata", (k < wq2.size()) ? wq2[k][31:0] : 32'hx,
          {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)});
    end
    s_valid = 1'b1;
    s_data = 8'hAA;
    repeat (3) begin
      @(negedge clk);
      chk("ovf_ready_low", o2_ready, 0);
    end
    s_valid = 1'b0;
    chk("ovf_cnt_hold", o2_cnt, 4);
    chk("ovf_nwrites_hold", wq2.size(), 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
